regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; clock port is clk, reset port is rst.
REQ-002 Parameter: INIT_VALUE, default 32'd0, value written to x1..x31 by the post-reset init sweep.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 a_valid  in  1  requester A (ALU writeback) has a write pending.
REQ-006 a_addr  in  5  requester A destination register.
REQ-007 a_data  in  32  requester A write data.
REQ-008 a_ready  out  1  requester A write accepted this cycle when a_valid=1.
REQ-009 b_valid  in  1  requester B (load unit) has a write pending.
REQ-010 b_addr  in  5  requester B destination register.
REQ-011 b_data  in  32  requester B write data.
REQ-012 b_ready  out  1  requester B write accepted this cycle when b_valid=1.
REQ-013 we3  out  1  register-file write enable, registered.
REQ-014 wa3  out  5  register-file write address, registered.
REQ-015 wd3  out  32  register-file write data, registered.
REQ-016 init_done  out  1  high once the init sweep has completed, registered.

Function
REQ-017 The block SHALL implement a two-state FSM: INIT (sweep) and RUN (arbitrate); reset enters INIT with sweep counter = 1.
REQ-018 In INIT, each clock edge SHALL load we3=1, wa3=counter, wd3=INIT_VALUE and increment counter; the edge loading wa3=31 SHALL also move the FSM to RUN and set init_done=1.
REQ-019 Timing: with E0 the first edge at which rst=0, the x1 write is presented after E0, x31 after E30, init_done=1 after E30; the sweep is exactly 31 consecutive write cycles with no gaps.
REQ-020 In INIT, a_ready and b_ready SHALL be 0.
REQ-021 In RUN: a_ready = !b_valid || prio==A; b_ready = !a_valid || prio==B; readies SHALL NOT depend on the requester's own valid.
REQ-022 A handshake is valid && ready at a clock edge; at most one handshake SHALL occur per edge.
REQ-023 prio register SHALL reset to A and SHALL flip to the other requester after every handshake, whether or not the other requester was valid; it SHALL hold when no handshake occurs.
REQ-024 Latency: a handshake at edge N SHALL present we3=1, wa3=addr, wd3=data after edge N, for exactly one cycle.
REQ-025 A handshake with addr==0 SHALL be accepted and counted for prio, but SHALL produce we3=0 in the following cycle (x0 writes dropped).
REQ-026 In RUN, an edge with no handshake SHALL load we3=0; wa3 and wd3 SHALL hold their previous values.
REQ-027 Back-to-back handshakes SHALL produce back-to-back writes at full throughput (one per cycle) with no bubbles.
REQ-028 Two requests to the same address in consecutive cycles SHALL be written in handshake order, so the later write wins.

Reset
REQ-029 An edge with rst=1 SHALL set we3=0, wa3=0, wd3=0, init_done=0, prio=A, counter=1, FSM=INIT; readies SHALL be 0 while in INIT.
REQ-030 Reset asserted mid-sweep or mid-RUN SHALL abort the operation; a write accepted at the edge coinciding with rst=1 SHALL be discarded and SHALL NOT appear on we3; the full sweep restarts from x1.

Verification
REQ-031 Reset release -> 31 consecutive cycles with we3=1, wa3=1..31 ascending, wd3=INIT_VALUE; init_done rises with the x31 write; readies stay 0 throughout.
REQ-032 RUN, only a_valid=1 with a_addr=5, a_data=32'hDEADBEEF -> a_ready=1; next cycle we3=1, wa3=5, wd3=32'hDEADBEEF; then we3=0.
REQ-033 RUN, a_valid and b_valid held high for 4 cycles with prio=A -> grant order A,B,A,B; we3 high for 4 consecutive cycles; neither requester is starved.
REQ-034 RUN, b_valid=1 with b_addr=0 -> b_ready=1, we3=0 next cycle, prio flips to A.
REQ-035 rst pulsed for one cycle while a_valid=1 and a_ready=1 in RUN -> no write of A's data appears; the sweep restarts at wa3=1; init_done=0 until x31 is written.
REQ-036 Regfile-attached bench: after init, A writes x7=32'h1234 and then B writes x7=32'h5678 on the next cycle -> regfile reads x7=32'h5678, and x0 reads 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between two requesters (ALU, load unit) and the register-file write port.
// The arbiter takes the slave side; requesters and the regfile take the master side.
interface regfile_wb_arbiter_if;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic        init_done;

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, we3, wa3, wd3, init_done
    );

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, we3, wa3, wd3, init_done
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter with alternating priority, preceded by a
// post-reset sweep that writes INIT_VALUE into x1..x31.
module regfile_wb_arbiter #(
    parameter logic [31:0] INIT_VALUE = 32'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic       PRIO_A  = 1'b0;

    logic [0:0]  state_reg, state_next;
    logic [4:0]  counter_reg, counter_next;
    logic        prio_reg, prio_next;
    logic        we3_reg, we3_next;
    logic [4:0]  wa3_reg, wa3_next;
    logic [31:0] wd3_reg, wd3_next;
    logic        init_done_reg, init_done_next;

    // Requester index 0 is A, index 1 is B; prio_reg holds the favoured index.
    logic [1:0]  valid, ready, hs;
    logic [4:0]  addr [2];
    logic [31:0] data [2];
    logic        sel;

    assign valid   = {bus.b_valid, bus.a_valid};
    assign addr[0] = bus.a_addr;
    assign addr[1] = bus.b_addr;
    assign data[0] = bus.a_data;
    assign data[1] = bus.b_data;

    // A requester is ready unless the other one is also asking and holds priority,
    // so the two readies can never both see a handshake in the same cycle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign ready[gi] = (state_reg == ST_RUN) &&
                               (!valid[1-gi] || (prio_reg == ((gi == 1) ? 1'b1 : 1'b0)));
            assign hs[gi]    = valid[gi] && ready[gi];
        end
    endgenerate

    assign sel = hs[1];

    always_comb begin
        state_next     = state_reg;
        counter_next   = counter_reg;
        prio_next      = prio_reg;
        we3_next       = we3_reg;
        wa3_next       = wa3_reg;
        wd3_next       = wd3_reg;
        init_done_next = init_done_reg;
        if (state_reg == ST_INIT) begin
            we3_next     = 1'b1;
            wa3_next     = counter_reg;
            wd3_next     = INIT_VALUE;
            counter_next = counter_reg + 5'd1;
            if (counter_reg == 5'd31) begin
                state_next     = ST_RUN;
                init_done_next = 1'b1;
            end
        end else begin
            we3_next = 1'b0;
            if (|hs) begin
                prio_next = ~prio_reg;
                // x0 writes are accepted but never reach the register file.
                if (addr[sel] != 5'd0) begin
                    we3_next = 1'b1;
                    wa3_next = addr[sel];
                    wd3_next = data[sel];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_INIT;
            counter_reg   <= 5'd1;
            prio_reg      <= PRIO_A;
            we3_reg       <= 1'b0;
            wa3_reg       <= 5'd0;
            wd3_reg       <= 32'd0;
            init_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            counter_reg   <= counter_next;
            prio_reg      <= prio_next;
            we3_reg       <= we3_next;
            wa3_reg       <= wa3_next;
            wd3_reg       <= wd3_next;
            init_done_reg <= init_done_next;
        end
    end

    assign bus.a_ready   = ready[0];
    assign bus.b_ready   = ready[1];
    assign bus.we3       = we3_reg;
    assign bus.wa3       = wa3_reg;
    assign bus.wd3       = wd3_reg;
    assign bus.init_done = init_done_reg;
endmodule
